regfile_phase_sequencer: RTL and testbench
==========================================

Name: regfile_phase_sequencer

Overview:
- Sequences the 16x16 register file through its three per-instruction phases, X (SSR update), Y (unconditional write) and Z (conditional write plus PC write), using one-cycle phase strobes.
- Multiplexes the file's single write port between the core datapath and a host/debug write requester.
- Handles run, single-step and stall control.
- Sits between the core control FSM and the register file; all register-file phase strobes originate here.

Parameters:
- ADDR_W, 4, register address width.
- DATA_W, 16, register data width.
- STARVE_LIMIT, 4, number of PZ phases a pending host request may be refused before a dedicated host phase is forced.

Ports:
- c_CLOCK  in  1  system clock.
- c_RESETn  in  1  synchronous reset, active-low.
- i_RUN  in  1  free-run enable (level).
- i_STEP  in  1  single-instruction request (one-cycle pulse, honoured only in IDLE).
- i_STALL  in  1  hold current phase, no strobe this cycle.
- i_CORE_WADDR  in  ADDR_W  core write address.
- i_CORE_DATA  in  DATA_W  core write data.
- i_CORE_WEN  in  1  core conditional write request for Z.
- i_CORE_PCDATA  in  DATA_W  next PC value.
- i_CORE_PCWEN  in  1  core PC write request for Z.
- i_HOST_REQ  in  1  host write request (level, held until ack).
- i_HOST_WADDR  in  ADDR_W  host write address.
- i_HOST_DATA  in  DATA_W  host write data.
- o_HOST_ACK  out  1  one-cycle acknowledge; the write occurs in this same cycle.
- o_CLOCKX, o_CLOCKY, o_CLOCKZ  out  1 each  phase strobes to the register file.
- o_WADDR  out  ADDR_W  write address to the register file.
- o_DATA  out  DATA_W  write data to the register file.
- o_WRITE  out  1  conditional write flag.
- o_PCDATA  out  DATA_W  PC data to the register file.
- o_PCWRITE  out  1  PC write flag.
- o_PHASE  out  3  current state encoding.
- o_HALTED  out  1  high in IDLE.

Behaviour:
- Reset values: state IDLE, starve counter 0, all strobes/o_WRITE/o_PCWRITE/o_HOST_ACK 0, o_WADDR/o_DATA/o_PCDATA 0, o_HALTED 1.
- States: IDLE, PX, PY, PZ, PH (host slot). The state register is registered; strobes decode combinationally from it.
- Strobe rule: o_CLOCKn = (state==Pn) && !i_STALL. The strobes are one-hot or all zero, and all are zero in IDLE. In PH, only o_CLOCKZ is asserted.
- i_STALL in PX/PY/PZ holds state and suppresses the strobe. In IDLE/PH it is ignored.
- Transitions:
  - IDLE: host pending -> PH; else i_RUN or i_STEP -> PX; else stay.
  - PX -> PY -> PZ (when not stalled).
  - PZ: host pending and (count>=STARVE_LIMIT or !i_RUN) -> PH; else i_RUN -> PX; else IDLE.
  - PH: i_RUN -> PX, else IDLE.
- Single step: i_STEP from IDLE with i_RUN=0 runs exactly one X,Y,Z sequence, then returns to IDLE (via PH if host pending).
- PY: o_WADDR/o_DATA take the core values; o_WRITE=0; o_PCWRITE=0.
- PZ, normal case: o_WRITE=i_CORE_WEN, o_PCWRITE=i_CORE_PCWEN, core address/data.
- PZ, opportunistic host grant: when i_CORE_WEN=0 and host pending, the host is granted in PZ, with two outcomes:
  - If not (i_HOST_WADDR==0 and i_CORE_PCWEN): o_WADDR/o_DATA take the host values, o_WRITE=1, o_HOST_ACK=1.
  - If i_HOST_WADDR==0 and i_CORE_PCWEN: host refused, so a PC update is never lost.
- PH: host address/data, o_WRITE=1, o_PCWRITE=0, o_HOST_ACK=1.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each non-stalled PZ where the host is pending and refused.
  - Clears on o_HOST_ACK.
  - Width is the minimum that holds STARVE_LIMIT.
- o_PCDATA always equals i_CORE_PCDATA. Register-file PC priority is preserved because a host write never coincides with a PC write to R0.
- Reset asserted mid-sequence: state returns to IDLE next edge, any pending host request is un-acked, strobes go low.

Optional Feature:
- REGSEQ_HOST_EN defined: host port, PH state and starvation logic present.
- Undefined: host inputs ignored, o_HOST_ACK tied 0, PH unreachable, PZ drives core values only.

Decomposition:
- Package regseq_pkg: state encoding constants (IDLE=0, PX=1, PY=2, PZ=3, PH=4), default ADDR_W/DATA_W, STARVE_LIMIT default.
- Sub-module regseq_host_arb: starve counter, PZ grant decision, R0/PC conflict check; outputs grant_pz and force_ph.

Test Plan:
- Reset, then i_RUN=1 for 9 cycles -> strobe order X,Y,Z x3, exactly one strobe per cycle, o_HALTED=0.
- i_STEP pulse in IDLE with i_RUN=0 -> X,Y,Z once, then IDLE; i_STALL=1 for 2 cycles during PY -> PY held, o_CLOCKY asserted once after the stall.
- Host REQ waddr=5 data=0xBEEF while core i_CORE_WEN=0 in PZ -> o_WRITE=1, o_WADDR=5, o_DATA=0xBEEF, o_HOST_ACK=1 in the PZ cycle.
- Host REQ waddr=0 with core i_CORE_PCWEN=1 every PZ and i_CORE_WEN=1 -> refused 4 PZ phases, then PH inserted after 4th PZ, ACK in PH, o_PCWRITE=0.
- Host REQ while halted -> IDLE->PH->IDLE, one o_CLOCKZ, ACK, no X/Y strobes.
- c_RESETn=0 during PY -> next cycle IDLE, all strobes 0, counter 0, ACK never asserted.

Source files
------------

// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file phase sequencer:
// phase state encoding and default widths / starvation limit.
package regseq_pkg;

    localparam int ADDR_W_DEF       = 4;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    // Encoding is visible on o_PHASE, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PX   = 3'd1,
        ST_PY   = 3'd2,
        ST_PZ   = 3'd3,
        ST_PH   = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_phase_sequencer_if.sv
// Host write request port and register-file write/strobe bus.
//
// Host handshake: the requester raises i_HOST_REQ with i_HOST_WADDR and
// i_HOST_DATA stable and holds all three until it sees o_HOST_ACK. o_HOST_ACK
// is high for exactly one cycle, the same cycle in which the register file
// is strobed with the host write; the requester may drop or change its
// request from the following cycle on.
interface regfile_phase_sequencer_if #(
    parameter int ADDR_W = regseq_pkg::ADDR_W_DEF,
    parameter int DATA_W = regseq_pkg::DATA_W_DEF
);
    logic              i_HOST_REQ;
    logic [ADDR_W-1:0] i_HOST_WADDR;
    logic [DATA_W-1:0] i_HOST_DATA;
    logic              o_HOST_ACK;

    logic              o_CLOCKX;
    logic              o_CLOCKY;
    logic              o_CLOCKZ;
    logic [ADDR_W-1:0] o_WADDR;
    logic [DATA_W-1:0] o_DATA;
    logic              o_WRITE;
    logic [DATA_W-1:0] o_PCDATA;
    logic              o_PCWRITE;

    // Sequencer side.
    modport master (
        input  i_HOST_REQ, i_HOST_WADDR, i_HOST_DATA,
        output o_HOST_ACK,
        output o_CLOCKX, o_CLOCKY, o_CLOCKZ,
        output o_WADDR, o_DATA, o_WRITE, o_PCDATA, o_PCWRITE
    );

    // Host requester / register file side.
    modport slave (
        output i_HOST_REQ, i_HOST_WADDR, i_HOST_DATA,
        input  o_HOST_ACK,
        input  o_CLOCKX, o_CLOCKY, o_CLOCKZ,
        input  o_WADDR, o_DATA, o_WRITE, o_PCDATA, o_PCWRITE
    );

endinterface

// File: rtl/regseq_host_arb.sv
// Host write arbitration: decides whether a pending host write can ride
// along in PZ, counts refused PZ phases and asks for a dedicated PH slot.
// Build option: REGSEQ_HOST_EN enables the host path; without it every
// output is held low and the host inputs are ignored.
module regseq_host_arb
    import regseq_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              c_CLOCK,
    input  logic              c_RESETn,
    input  logic              i_PZ_ACTIVE,   // non-stalled PZ cycle
    input  logic              i_RUN,
    input  logic              i_HOST_REQ,
    input  logic [ADDR_W-1:0] i_HOST_WADDR,
    input  logic              i_CORE_WEN,
    input  logic              i_CORE_PCWEN,
    input  logic              i_HOST_ACK,
    output logic              o_HOST_PEND,
    output logic              o_GRANT_PZ,
    output logic              o_FORCE_PH
);

`ifdef REGSEQ_HOST_EN
    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             pc_conflict;
    logic             refused;

    // A host write to R0 must not share a Z phase with a PC write.
    assign pc_conflict = (i_HOST_WADDR == '0) && i_CORE_PCWEN;
    assign o_HOST_PEND = i_HOST_REQ;
    assign o_GRANT_PZ  = i_HOST_REQ && !i_CORE_WEN && !pc_conflict;
    assign refused     = i_PZ_ACTIVE && i_HOST_REQ && !o_GRANT_PZ;
    assign cnt_inc     = (refused && (cnt_q < LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    // The refusal happening now counts, so the slot follows the LIMIT-th refusal.
    assign o_FORCE_PH  = i_HOST_REQ && !o_GRANT_PZ && ((cnt_inc >= LIMIT) || !i_RUN);

    // Saturating starvation counter, cleared whenever the host is served.
    always_ff @(posedge c_CLOCK) begin
        if (!c_RESETn) begin
            cnt_q <= '0;
        end else if (i_HOST_ACK) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_inc;
        end
    end
`else
    logic unused_arb;

    assign o_HOST_PEND = 1'b0;
    assign o_GRANT_PZ  = 1'b0;
    assign o_FORCE_PH  = 1'b0;
    assign unused_arb  = ^{c_CLOCK, c_RESETn, i_PZ_ACTIVE, i_RUN, i_HOST_REQ,
                           i_HOST_WADDR, i_CORE_WEN, i_CORE_PCWEN, i_HOST_ACK,
                           1'(STARVE_LIMIT)};
`endif

endmodule

// File: rtl/regfile_phase_sequencer.sv
// Drives the 16x16 register file through its X/Y/Z phases with one-cycle
// strobes, shares the single write port between core and host, and handles
// run / single-step / stall. State is exposed on o_PHASE.
// Build option: REGSEQ_HOST_EN enables the host write port and PH slot.
module regfile_phase_sequencer
    import regseq_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                      c_CLOCK,
    input  logic                      c_RESETn,
    input  logic                      i_RUN,
    input  logic                      i_STEP,
    input  logic                      i_STALL,
    input  logic [ADDR_W-1:0]         i_CORE_WADDR,
    input  logic [DATA_W-1:0]         i_CORE_DATA,
    input  logic                      i_CORE_WEN,
    input  logic [DATA_W-1:0]         i_CORE_PCDATA,
    input  logic                      i_CORE_PCWEN,
    regfile_phase_sequencer_if.master bus,
    output logic [2:0]                o_PHASE,
    output logic                      o_HALTED
);

    state_t            state_q;
    state_t            state_d;
    logic              host_pend;
    logic              grant_pz;
    logic              force_ph;
    logic              pz_active;
    logic              host_ack;
    logic              clk_x;
    logic              clk_y;
    logic              clk_z;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              pcwrite;

    assign pz_active = (state_q == ST_PZ) && !i_STALL;

    regseq_host_arb #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_host_arb (
        .c_CLOCK      (c_CLOCK),
        .c_RESETn     (c_RESETn),
        .i_PZ_ACTIVE  (pz_active),
        .i_RUN        (i_RUN),
        .i_HOST_REQ   (bus.i_HOST_REQ),
        .i_HOST_WADDR (bus.i_HOST_WADDR),
        .i_CORE_WEN   (i_CORE_WEN),
        .i_CORE_PCWEN (i_CORE_PCWEN),
        .i_HOST_ACK   (host_ack),
        .o_HOST_PEND  (host_pend),
        .o_GRANT_PZ   (grant_pz),
        .o_FORCE_PH   (force_ph)
    );

    // Phase state register.
    always_ff @(posedge c_CLOCK) begin
        if (!c_RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase plus strobe / write-port decode from the current phase.
    always_comb begin
        state_d  = state_q;
        clk_x    = 1'b0;
        clk_y    = 1'b0;
        clk_z    = 1'b0;
        waddr    = '0;
        wdata    = '0;
        write    = 1'b0;
        pcwrite  = 1'b0;
        host_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_pend) begin
                    state_d = ST_PH;
                end else if (i_RUN || i_STEP) begin
                    state_d = ST_PX;
                end
            end
            ST_PX: begin
                clk_x = !i_STALL;
                if (!i_STALL) state_d = ST_PY;
            end
            ST_PY: begin
                clk_y = !i_STALL;
                waddr = i_CORE_WADDR;
                wdata = i_CORE_DATA;
                if (!i_STALL) state_d = ST_PZ;
            end
            ST_PZ: begin
                clk_z   = !i_STALL;
                pcwrite = i_CORE_PCWEN;
                if (grant_pz) begin
                    // Core has no register write this phase: lend the port to the host.
                    waddr    = bus.i_HOST_WADDR;
                    wdata    = bus.i_HOST_DATA;
                    write    = 1'b1;
                    host_ack = !i_STALL;
                end else begin
                    waddr = i_CORE_WADDR;
                    wdata = i_CORE_DATA;
                    write = i_CORE_WEN;
                end
                if (!i_STALL) begin
                    if (force_ph) begin
                        state_d = ST_PH;
                    end else if (i_RUN) begin
                        state_d = ST_PX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PH: begin
                // Dedicated host slot reuses the Z write path; stall does not apply.
                clk_z    = 1'b1;
                waddr    = bus.i_HOST_WADDR;
                wdata    = bus.i_HOST_DATA;
                write    = 1'b1;
                host_ack = 1'b1;
                state_d  = i_RUN ? ST_PX : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_CLOCKX   = clk_x;
    assign bus.o_CLOCKY   = clk_y;
    assign bus.o_CLOCKZ   = clk_z;
    assign bus.o_WADDR    = waddr;
    assign bus.o_DATA     = wdata;
    assign bus.o_WRITE    = write;
    assign bus.o_PCDATA   = i_CORE_PCDATA;
    assign bus.o_PCWRITE  = pcwrite;
    assign bus.o_HOST_ACK = host_ack;
    assign o_PHASE        = state_q;
    assign o_HALTED       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_regfile_phase_sequencer.sv
// Bench for regfile_phase_sequencer: vector table of per-cycle inputs and
// expected outputs, plus a stalled free-run strobe-order sequence.
module tb_regfile_phase_sequencer;
    import regseq_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int OW = 3 + 3 + 4 + AW + DW + DW;

    localparam logic [2:0] P_I = 3'd0, P_X = 3'd1, P_Y = 3'd2, P_Z = 3'd3, P_H = 3'd4;
    localparam logic [2:0] S_N = 3'b000, S_X = 3'b100, S_Y = 3'b010, S_Z = 3'b001;
    localparam logic [1:0] D_0 = 2'd0, D_C = 2'd1, D_H = 2'd2;

    typedef struct {
        string       tag;
        logic        rst_n, run, step, stall, hreq;
        logic [3:0]  hwa;
        logic [15:0] hd;
        logic        cwen, cpcwen;
        logic [2:0]  ph, xyz;
        logic        wr, pcwr, ack;
        logic [1:0]  sel;
    } vec_t;

    logic          c_CLOCK = 1'b0;
    logic          c_RESETn = 1'b0;
    logic          i_RUN = 1'b0, i_STEP = 1'b0, i_STALL = 1'b0;
    logic [AW-1:0] i_CORE_WADDR = '0;
    logic [DW-1:0] i_CORE_DATA = '0, i_CORE_PCDATA = '0;
    logic          i_CORE_WEN = 1'b0, i_CORE_PCWEN = 1'b0;
    logic [2:0]    o_PHASE;
    logic          o_HALTED;

    vec_t          vec_q[$];
    logic [OW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    regfile_phase_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_phase_sequencer #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .c_CLOCK       (c_CLOCK),
        .c_RESETn      (c_RESETn),
        .i_RUN         (i_RUN),
        .i_STEP        (i_STEP),
        .i_STALL       (i_STALL),
        .i_CORE_WADDR  (i_CORE_WADDR),
        .i_CORE_DATA   (i_CORE_DATA),
        .i_CORE_WEN    (i_CORE_WEN),
        .i_CORE_PCDATA (i_CORE_PCDATA),
        .i_CORE_PCWEN  (i_CORE_PCWEN),
        .bus           (bus),
        .o_PHASE       (o_PHASE),
        .o_HALTED      (o_HALTED)
    );

    // Clock.
    always #5 c_CLOCK = ~c_CLOCK;

    function automatic logic [OW-1:0] observed();
        return {o_PHASE, bus.o_CLOCKX, bus.o_CLOCKY, bus.o_CLOCKZ, bus.o_WRITE,
                bus.o_PCWRITE, bus.o_HOST_ACK, o_HALTED, bus.o_WADDR, bus.o_DATA,
                bus.o_PCDATA};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic add(input string tag, input logic rst_n, run, step, stall, hreq,
                       input logic [3:0] hwa, input logic [15:0] hd, input logic cwen, cpcwen,
                       input logic [2:0] ph, xyz, input logic wr, pcwr, ack, input logic [1:0] sel);
        vec_t v;
        v.tag = tag; v.rst_n = rst_n; v.run = run; v.step = step; v.stall = stall;
        v.hreq = hreq; v.hwa = hwa; v.hd = hd; v.cwen = cwen; v.cpcwen = cpcwen;
        v.ph = ph; v.xyz = xyz; v.wr = wr; v.pcwr = pcwr; v.ack = ack; v.sel = sel;
        vec_q.push_back(v);
    endtask

    // Drive one vector, queue its expected outputs, compare mid-cycle.
    task automatic apply(input vec_t v);
        logic [AW-1:0] ew;
        logic [DW-1:0] ed;
        logic [OW-1:0] exp_v;
        c_RESETn = v.rst_n; i_RUN = v.run; i_STEP = v.step; i_STALL = v.stall;
        bus.i_HOST_REQ = v.hreq; bus.i_HOST_WADDR = v.hwa; bus.i_HOST_DATA = v.hd;
        i_CORE_WEN = v.cwen; i_CORE_PCWEN = v.cpcwen;
        i_CORE_WADDR = AW'($urandom_range(0, 15));
        i_CORE_DATA = DW'($urandom_range(0, 65535));
        i_CORE_PCDATA = DW'($urandom_range(0, 65535));
        ew = (v.sel == D_C) ? i_CORE_WADDR : (v.sel == D_H) ? v.hwa : '0;
        ed = (v.sel == D_C) ? i_CORE_DATA : (v.sel == D_H) ? v.hd : '0;
        exp_v = {v.ph, v.xyz, v.wr, v.pcwr, v.ack, (v.ph == P_I), ew, ed, i_CORE_PCDATA};
        exp_q.push_back(exp_v);
        @(negedge c_CLOCK);
        check(v.tag, 64'(observed()), 64'(exp_q.pop_front()));
        @(posedge c_CLOCK);
        #1;
    endtask

    initial begin
        logic [2:0] nxt;
        logic       stl;
        bool_done: begin end
        bus.i_HOST_REQ = 1'b0; bus.i_HOST_WADDR = '0; bus.i_HOST_DATA = '0;
        repeat (2) @(posedge c_CLOCK);
        #1;

        // Reset, free run of three instructions, then run dropped.
        add("rst",       0,0,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("idle_run",  1,1,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("run_x1",    1,1,0,0,0, 4'd0,16'h0, 1,1, P_X,S_X,0,0,0,D_0);
        add("run_y1",    1,1,0,0,0, 4'd0,16'h0, 1,1, P_Y,S_Y,0,0,0,D_C);
        add("run_z1",    1,1,0,0,0, 4'd0,16'h0, 1,1, P_Z,S_Z,1,1,0,D_C);
        add("run_x2",    1,1,0,0,0, 4'd0,16'h0, 1,0, P_X,S_X,0,0,0,D_0);
        add("run_y2",    1,1,0,0,0, 4'd0,16'h0, 1,0, P_Y,S_Y,0,0,0,D_C);
        add("run_z2",    1,1,0,0,0, 4'd0,16'h0, 1,0, P_Z,S_Z,1,0,0,D_C);
        add("run_x3",    1,1,0,0,0, 4'd0,16'h0, 0,1, P_X,S_X,0,0,0,D_0);
        add("run_y3",    1,1,0,0,0, 4'd0,16'h0, 0,1, P_Y,S_Y,0,0,0,D_C);
        add("run_z3",    1,1,0,0,0, 4'd0,16'h0, 0,1, P_Z,S_Z,0,1,0,D_C);
        add("stop_x",    1,0,0,0,0, 4'd0,16'h0, 0,0, P_X,S_X,0,0,0,D_0);
        add("stop_y",    1,0,0,0,0, 4'd0,16'h0, 0,0, P_Y,S_Y,0,0,0,D_C);
        add("stop_z",    1,0,0,0,0, 4'd0,16'h0, 0,0, P_Z,S_Z,0,0,0,D_C);
        add("halt",      1,0,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        // Single step with a two-cycle stall in PY.
        add("step",      1,0,1,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("step_x",    1,0,0,0,0, 4'd0,16'h0, 0,0, P_X,S_X,0,0,0,D_0);
        add("stall_y1",  1,0,0,1,0, 4'd0,16'h0, 0,0, P_Y,S_N,0,0,0,D_C);
        add("stall_y2",  1,0,0,1,0, 4'd0,16'h0, 0,0, P_Y,S_N,0,0,0,D_C);
        add("step_y",    1,0,0,0,0, 4'd0,16'h0, 0,0, P_Y,S_Y,0,0,0,D_C);
        add("step_z",    1,0,0,0,0, 4'd0,16'h0, 1,0, P_Z,S_Z,1,0,0,D_C);
        add("step_done", 1,0,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("idle_stall",1,0,0,1,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        // Reset asserted during PY.
        add("r_run",     1,1,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("r_x",       1,1,0,0,0, 4'd0,16'h0, 0,0, P_X,S_X,0,0,0,D_0);
        add("r_y_rst",   0,1,0,0,0, 4'd0,16'h0, 0,0, P_Y,S_Y,0,0,0,D_C);
        add("r_idle",    0,1,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
        add("r_rel",     1,0,0,0,0, 4'd0,16'h0, 0,0, P_I,S_N,0,0,0,D_0);
`ifdef REGSEQ_HOST_EN
        // Opportunistic host grant in PZ.
        add("c_run",     1,1,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
        add("c_x",       1,1,0,0,0, 4'd0,16'h0,    0,0, P_X,S_X,0,0,0,D_0);
        add("c_y",       1,1,0,0,0, 4'd0,16'h0,    0,0, P_Y,S_Y,0,0,0,D_C);
        add("c_z_grant", 1,1,0,0,1, 4'd5,16'hBEEF, 0,1, P_Z,S_Z,1,1,1,D_H);
        add("c_x2",      1,0,0,0,0, 4'd0,16'h0,    0,0, P_X,S_X,0,0,0,D_0);
        add("c_y2",      1,0,0,0,0, 4'd0,16'h0,    0,0, P_Y,S_Y,0,0,0,D_C);
        add("c_z2",      1,0,0,0,0, 4'd0,16'h0,    0,0, P_Z,S_Z,0,0,0,D_C);
        add("c_idle",    1,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
        // R0 host write refused four times against PC writes, then PH.
        add("d_run",     1,1,0,0,0, 4'd0,16'h0,    1,1, P_I,S_N,0,0,0,D_0);
        for (int k = 1; k <= 4; k++) begin
            add($sformatf("d_x%0d", k), 1,1,0,0,1, 4'd0,16'h1111, 1,1, P_X,S_X,0,0,0,D_0);
            add($sformatf("d_y%0d", k), 1,1,0,0,1, 4'd0,16'h1111, 1,1, P_Y,S_Y,0,0,0,D_C);
            add($sformatf("d_z%0d", k), 1,1,0,0,1, 4'd0,16'h1111, 1,1, P_Z,S_Z,1,1,0,D_C);
        end
        add("d_ph",      1,0,0,0,1, 4'd0,16'h1111, 1,1, P_H,S_Z,1,0,1,D_H);
        add("d_idle",    1,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
        // Host request while halted.
        add("e_req",     1,0,0,0,1, 4'd9,16'h5A5A, 0,0, P_I,S_N,0,0,0,D_0);
        add("e_ph",      1,0,0,0,1, 4'd9,16'h5A5A, 0,0, P_H,S_Z,1,0,1,D_H);
        add("e_idle",    1,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
        // Two refusals, reset during PY, then the count restarts from zero.
        add("f_run",     1,1,0,0,0, 4'd0,16'h0,    1,1, P_I,S_N,0,0,0,D_0);
        for (int k = 1; k <= 2; k++) begin
            add($sformatf("f_x%0d", k), 1,1,0,0,1, 4'd0,16'h2222, 1,1, P_X,S_X,0,0,0,D_0);
            add($sformatf("f_y%0d", k), 1,1,0,0,1, 4'd0,16'h2222, 1,1, P_Y,S_Y,0,0,0,D_C);
            add($sformatf("f_z%0d", k), 1,1,0,0,1, 4'd0,16'h2222, 1,1, P_Z,S_Z,1,1,0,D_C);
        end
        add("f_x3",      1,1,0,0,1, 4'd0,16'h2222, 1,1, P_X,S_X,0,0,0,D_0);
        add("f_y3_rst",  0,1,0,0,1, 4'd0,16'h2222, 1,1, P_Y,S_Y,0,0,0,D_C);
        add("f_rst",     0,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
        add("f_rel",     1,1,0,0,0, 4'd0,16'h0,    1,1, P_I,S_N,0,0,0,D_0);
        for (int k = 1; k <= 3; k++) begin
            add($sformatf("g_x%0d", k), 1,1,0,0,1, 4'd0,16'h3333, 1,1, P_X,S_X,0,0,0,D_0);
            add($sformatf("g_y%0d", k), 1,1,0,0,1, 4'd0,16'h3333, 1,1, P_Y,S_Y,0,0,0,D_C);
            add($sformatf("g_z%0d", k), 1,1,0,0,1, 4'd0,16'h3333, 1,1, P_Z,S_Z,1,1,0,D_C);
        end
        add("g_x4",      1,0,0,0,1, 4'd0,16'h3333, 1,1, P_X,S_X,0,0,0,D_0);
        add("g_y4",      1,0,0,0,1, 4'd0,16'h3333, 1,1, P_Y,S_Y,0,0,0,D_C);
        add("g_z4",      1,0,0,0,1, 4'd0,16'h3333, 1,1, P_Z,S_Z,1,1,0,D_C);
        add("g_ph",      1,0,0,0,1, 4'd0,16'h3333, 1,1, P_H,S_Z,1,0,1,D_H);
        add("g_idle",    1,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
`else
        // Host port absent: requests never acknowledged, PH never entered.
        add("n_req",     1,0,0,0,1, 4'd5,16'hBEEF, 0,0, P_I,S_N,0,0,0,D_0);
        add("n_run",     1,1,0,0,1, 4'd5,16'hBEEF, 0,0, P_I,S_N,0,0,0,D_0);
        add("n_x",       1,1,0,0,1, 4'd5,16'hBEEF, 0,0, P_X,S_X,0,0,0,D_0);
        add("n_y",       1,1,0,0,1, 4'd5,16'hBEEF, 0,0, P_Y,S_Y,0,0,0,D_C);
        add("n_z",       1,0,0,0,1, 4'd5,16'hBEEF, 0,0, P_Z,S_Z,0,0,0,D_C);
        add("n_idle",    1,0,0,0,0, 4'd0,16'h0,    0,0, P_I,S_N,0,0,0,D_0);
`endif
        for (int i = 0; i < vec_q.size(); i++) begin
            apply(vec_q[i]);
        end

        // Free run with random stalls: strobes stay in X,Y,Z order, one at most per cycle.
        i_RUN = 1'b1; i_STALL = 1'b0; i_STEP = 1'b0; bus.i_HOST_REQ = 1'b0;
        @(negedge c_CLOCK);
        check("soak_start", 64'({o_HALTED, o_PHASE}), 64'({1'b1, P_I}));
        @(posedge c_CLOCK);
        #1;
        nxt = S_X;
        for (int c = 0; c < 40; c++) begin
            stl = ($urandom_range(0, 3) == 0);
            i_STALL = stl;
            exp_q.push_back(OW'({1'b0, stl ? S_N : nxt}));
            @(negedge c_CLOCK);
            check($sformatf("soak%0d", c),
                  64'({o_HALTED, bus.o_CLOCKX, bus.o_CLOCKY, bus.o_CLOCKZ}),
                  64'(exp_q.pop_front()));
            if (!stl) nxt = {nxt[0], nxt[2:1]};
            @(posedge c_CLOCK);
            #1;
        end

        // Drop run; the sequencer must halt within one instruction.
        i_RUN = 1'b0; i_STALL = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!o_HALTED && waited < 8) begin
                @(posedge c_CLOCK);
                #1;
                waited++;
            end
            check("halt_timeout", 64'(o_HALTED), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
